// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the debug-entry logic: the controller state
// encoding, the dcsr.cause codes and the breakpoint exception cause.
// halt_cause() resolves simultaneous halt sources to a single cause.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2,
    ST_RESUME = 2'd3
  } dbg_state_e;

  localparam logic [2:0] DCSR_CAUSE_EBREAK       = 3'd1;
  localparam logic [2:0] DCSR_CAUSE_TRIGGER      = 3'd2;
  localparam logic [2:0] DCSR_CAUSE_HALTREQ      = 3'd3;
  localparam logic [2:0] DCSR_CAUSE_STEP         = 3'd4;
  localparam logic [2:0] DCSR_CAUSE_RESETHALTREQ = 3'd5;

  localparam logic [3:0] EXC_CAUSE_BREAKPOINT = 4'd3;

  // Only meaningful when some halt source is active; with none of the
  // first three set, the remaining source must be a completed step.
  function automatic logic [2:0] halt_cause(input logic trigger,
                                            input logic ebreak,
                                            input logic haltreq);
    if (trigger)      return DCSR_CAUSE_TRIGGER;
    else if (ebreak)  return DCSR_CAUSE_EBREAK;
    else if (haltreq) return DCSR_CAUSE_HALTREQ;
    else              return DCSR_CAUSE_STEP;
  endfunction

endpackage

// File: rtl/debug_entry_ctrl_if.sv
// debug_entry_ctrl_if
// Bundles the core/DM-facing signals of debug_entry_ctrl.
//   master : the core and debug module side (drives requests, sees status)
//   slave  : the controller side (sees requests, drives status/CSR writes)
interface debug_entry_ctrl_if;
  logic        trigger_fire_i;
  logic        trigger_exception_req_i;
  logic        ebreak_i;
  logic        haltreq_i;
  logic        resumereq_i;
  logic        dret_i;
  logic        step_i;
  logic        instruction_retired_i;
  logic [31:0] pc_i;
  logic        pipe_idle_i;
  logic        flush_req_o;
  logic        debug_mode_o;
  logic        halted_o;
  logic        resumeack_o;
  logic        dpc_we_o;
  logic [31:0] dpc_o;
  logic        dcsr_cause_we_o;
  logic [2:0]  dcsr_cause_o;
  logic        exc_req_o;
  logic [3:0]  exc_cause_o;
  logic [31:0] exc_tval_o;

  modport master (
    output trigger_fire_i, trigger_exception_req_i, ebreak_i, haltreq_i,
           resumereq_i, dret_i, step_i, instruction_retired_i, pc_i,
           pipe_idle_i,
    input  flush_req_o, debug_mode_o, halted_o, resumeack_o, dpc_we_o,
           dpc_o, dcsr_cause_we_o, dcsr_cause_o, exc_req_o, exc_cause_o,
           exc_tval_o
  );

  modport slave (
    input  trigger_fire_i, trigger_exception_req_i, ebreak_i, haltreq_i,
           resumereq_i, dret_i, step_i, instruction_retired_i, pc_i,
           pipe_idle_i,
    output flush_req_o, debug_mode_o, halted_o, resumeack_o, dpc_we_o,
           dpc_o, dcsr_cause_we_o, dcsr_cause_o, exc_req_o, exc_cause_o,
           exc_tval_o
  );
endinterface

// File: rtl/debug_entry_ctrl.sv
// debug_entry_ctrl
// Decides when the hart enters and leaves Debug Mode. A halt source in RUN
// (trigger, ebreak, DM haltreq, completed single step) latches cause and PC,
// flushes the pipeline until it drains or FLUSH_TIMEOUT expires, then writes
// dpc/dcsr.cause and reports halted. Resume (dret or DM resumereq) goes
// through a one-cycle RESUME state that acknowledges and arms single step.
// Trigger "raise exception" requests become a one-cycle breakpoint exception.
// Ports:
//   clk, reset_n (async, active-low)
//   inputs : trigger_fire_i, trigger_exception_req_i, ebreak_i, haltreq_i,
//            resumereq_i, dret_i, step_i, instruction_retired_i, pc_i[31:0],
//            pipe_idle_i
//   outputs: flush_req_o, debug_mode_o, halted_o, resumeack_o, dpc_we_o,
//            dpc_o[31:0], dcsr_cause_we_o, dcsr_cause_o[2:0], exc_req_o,
//            exc_cause_o[3:0], exc_tval_o[31:0]
module debug_entry_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trigger_fire_i,
  input  logic        trigger_exception_req_i,
  input  logic        ebreak_i,
  input  logic        haltreq_i,
  input  logic        resumereq_i,
  input  logic        dret_i,
  input  logic        step_i,
  input  logic        instruction_retired_i,
  input  logic [31:0] pc_i,
  input  logic        pipe_idle_i,
  output logic        flush_req_o,
  output logic        debug_mode_o,
  output logic        halted_o,
  output logic        resumeack_o,
  output logic        dpc_we_o,
  output logic [31:0] dpc_o,
  output logic        dcsr_cause_we_o,
  output logic [2:0]  dcsr_cause_o,
  output logic        exc_req_o,
  output logic [3:0]  exc_cause_o,
  output logic [31:0] exc_tval_o
);

  localparam int CNT_MIN_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam int CNT_W     = (CNT_MIN_W > 8) ? CNT_MIN_W : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(FLUSH_TIMEOUT);

  dbg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        cause_q, cause_d;
  logic [31:0]       dpc_q, dpc_d;
  logic              step_pending_q, step_pending_d;
  logic              csr_we_q, csr_we_d;
  logic              exc_req_q, exc_req_d;
  logic [31:0]       exc_tval_q, exc_tval_d;
  logic              step_done;
  logic              halt_ev;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cause_d        = cause_q;
    dpc_d          = dpc_q;
    step_pending_d = step_pending_q;
    exc_tval_d     = exc_tval_q;
    csr_we_d       = 1'b0;
    exc_req_d      = 1'b0;
    step_done      = 1'b0;
    halt_ev        = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        step_done = step_pending_q & instruction_retired_i;
        halt_ev   = trigger_fire_i | ebreak_i | haltreq_i | step_done;
        // The step is consumed by the retire even if another source wins.
        if (step_done) step_pending_d = 1'b0;
        if (halt_ev) begin
          cause_d = halt_cause(trigger_fire_i, ebreak_i, haltreq_i);
          dpc_d   = pc_i;
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else if (trigger_exception_req_i) begin
          exc_req_d  = 1'b1;
          exc_tval_d = pc_i;
        end
      end
      ST_FLUSH: begin
        // Count saturates at the timeout; reaching it forces entry.
        if (pipe_idle_i || (cnt_q == TIMEOUT_CNT)) begin
          state_d  = ST_HALTED;
          csr_we_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        // A resume request is not honoured while the DM still asks to halt.
        if (dret_i || (resumereq_i && !haltreq_i)) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        step_pending_d = step_i;
        state_d        = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      cause_q        <= '0;
      dpc_q          <= '0;
      step_pending_q <= 1'b0;
      csr_we_q       <= 1'b0;
      exc_req_q      <= 1'b0;
      exc_tval_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cause_q        <= cause_d;
      dpc_q          <= dpc_d;
      step_pending_q <= step_pending_d;
      csr_we_q       <= csr_we_d;
      exc_req_q      <= exc_req_d;
      exc_tval_q     <= exc_tval_d;
    end
  end

  assign flush_req_o     = (state_q == ST_FLUSH) || (state_q == ST_HALTED);
  assign debug_mode_o    = (state_q == ST_HALTED);
  assign halted_o        = (state_q == ST_HALTED);
  assign resumeack_o     = (state_q == ST_RESUME);
  assign dpc_we_o        = csr_we_q;
  assign dpc_o           = dpc_q;
  assign dcsr_cause_we_o = csr_we_q;
  assign dcsr_cause_o    = cause_q;
  assign exc_req_o       = exc_req_q;
  assign exc_cause_o     = EXC_CAUSE_BREAKPOINT;
  assign exc_tval_o      = exc_tval_q;

endmodule

// File: tb/tb_debug_entry_ctrl.sv
// tb_debug_entry_ctrl
// Directed scenarios followed by randomized traffic, all scored against a
// cycle-level behavioural model of debug entry/exit kept in this file.
module tb_debug_entry_ctrl;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  debug_entry_ctrl_if dif();

  debug_entry_ctrl #(.FLUSH_TIMEOUT(TO)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .trigger_fire_i          (dif.trigger_fire_i),
    .trigger_exception_req_i (dif.trigger_exception_req_i),
    .ebreak_i                (dif.ebreak_i),
    .haltreq_i               (dif.haltreq_i),
    .resumereq_i             (dif.resumereq_i),
    .dret_i                  (dif.dret_i),
    .step_i                  (dif.step_i),
    .instruction_retired_i   (dif.instruction_retired_i),
    .pc_i                    (dif.pc_i),
    .pipe_idle_i             (dif.pipe_idle_i),
    .flush_req_o             (dif.flush_req_o),
    .debug_mode_o            (dif.debug_mode_o),
    .halted_o                (dif.halted_o),
    .resumeack_o             (dif.resumeack_o),
    .dpc_we_o                (dif.dpc_we_o),
    .dpc_o                   (dif.dpc_o),
    .dcsr_cause_we_o         (dif.dcsr_cause_we_o),
    .dcsr_cause_o            (dif.dcsr_cause_o),
    .exc_req_o               (dif.exc_req_o),
    .exc_cause_o             (dif.exc_cause_o),
    .exc_tval_o              (dif.exc_tval_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: flush_age < 0 means not flushing; otherwise it is the
  // number of flush cycles already spent.
  int          m_flush_age;
  bit          m_halted, m_resume, m_armed, m_we, m_exc;
  logic [31:0] m_dpc, m_tval;
  logic [2:0]  m_cause;

  task automatic model_reset();
    m_flush_age = -1;
    m_halted = 0; m_resume = 0; m_armed = 0; m_we = 0; m_exc = 0;
    m_dpc = '0; m_tval = '0; m_cause = '0;
  endtask

  task automatic model_clock();
    bit running, hit;
    int c;
    running = (m_flush_age < 0) && !m_halted && !m_resume;
    m_we = 0;
    m_exc = 0;
    if (running) begin
      hit = m_armed && dif.instruction_retired_i;
      if (hit) m_armed = 0;
      c = 0;
      if (dif.trigger_fire_i)  c = 2;
      else if (dif.ebreak_i)   c = 1;
      else if (dif.haltreq_i)  c = 3;
      else if (hit)            c = 4;
      if (c != 0) begin
        m_cause = 3'(c);
        m_dpc = dif.pc_i;
        m_flush_age = 0;
      end else if (dif.trigger_exception_req_i) begin
        m_exc = 1;
        m_tval = dif.pc_i;
      end
    end else if (m_flush_age >= 0) begin
      if (dif.pipe_idle_i || m_flush_age == TO) begin
        m_flush_age = -1;
        m_halted = 1;
        m_we = 1;
      end else begin
        m_flush_age++;
      end
    end else if (m_halted) begin
      if (dif.dret_i || (dif.resumereq_i && !dif.haltreq_i)) begin
        m_halted = 0;
        m_resume = 1;
      end
    end else begin
      m_resume = 0;
      m_armed = dif.step_i;
    end
  endtask

  task automatic check_outputs();
    chk("flush_req", 32'(dif.flush_req_o), 32'((m_flush_age >= 0) || m_halted));
    chk("debug_mode", 32'(dif.debug_mode_o), 32'(m_halted));
    chk("halted", 32'(dif.halted_o), 32'(m_halted));
    chk("resumeack", 32'(dif.resumeack_o), 32'(m_resume));
    chk("dpc_we", 32'(dif.dpc_we_o), 32'(m_we));
    chk("cause_we", 32'(dif.dcsr_cause_we_o), 32'(m_we));
    chk("exc_req", 32'(dif.exc_req_o), 32'(m_exc));
    chk("exc_cause", 32'(dif.exc_cause_o), 32'd3);
    if (m_we) begin
      chk("dpc", dif.dpc_o, m_dpc);
      chk("dcsr_cause", 32'(dif.dcsr_cause_o), 32'(m_cause));
    end
    if (m_exc) chk("exc_tval", dif.exc_tval_o, m_tval);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic clr();
    dif.trigger_fire_i = 0; dif.trigger_exception_req_i = 0; dif.ebreak_i = 0;
    dif.haltreq_i = 0; dif.resumereq_i = 0; dif.dret_i = 0; dif.step_i = 0;
    dif.instruction_retired_i = 0; dif.pc_i = '0; dif.pipe_idle_i = 0;
  endtask

  task automatic async_reset();
    reset_n = 0;
    #2;
    model_reset();
    check_outputs();
    chk("rst_dpc", dif.dpc_o, 32'd0);
    chk("rst_cause", 32'(dif.dcsr_cause_o), 32'd0);
    chk("rst_tval", dif.exc_tval_o, 32'd0);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic halt_now();
    clr(); dif.ebreak_i = 1; tick();
    clr(); dif.pipe_idle_i = 1; tick();
    clr();
  endtask

  task automatic resume_now();
    clr(); dif.resumereq_i = 1; tick();
    clr(); tick();
  endtask

  initial begin
    clr();
    model_reset();
    reset_n = 0;
    #12;
    check_outputs();
    chk("rst_dpc", dif.dpc_o, 32'd0);
    @(negedge clk);
    reset_n = 1;

    // Trigger halt with a three-cycle drain.
    clr(); dif.pc_i = 32'h8000_0010; dif.trigger_fire_i = 1; tick();
    chk("t21_flush", 32'(dif.flush_req_o), 32'd1);
    clr(); dif.pc_i = 32'h0000_1234; tick(); tick();
    dif.pipe_idle_i = 1; tick();
    chk("t21_halted", 32'(dif.halted_o), 32'd1);
    chk("t21_dpc", dif.dpc_o, 32'h8000_0010);
    chk("t21_cause", 32'(dif.dcsr_cause_o), 32'd2);
    clr(); dif.resumereq_i = 1; tick();
    chk("t21_rack", 32'(dif.resumeack_o), 32'd1);
    clr(); tick();
    chk("t21_run", 32'(dif.flush_req_o), 32'd0);

    // Cause priority.
    clr(); dif.trigger_fire_i = 1; dif.ebreak_i = 1; dif.haltreq_i = 1; tick();
    clr(); dif.pipe_idle_i = 1; tick();
    chk("t22_cause_all", 32'(dif.dcsr_cause_o), 32'd2);
    resume_now();
    clr(); dif.ebreak_i = 1; dif.haltreq_i = 1; tick();
    clr(); dif.pipe_idle_i = 1; tick();
    chk("t22_cause_eb", 32'(dif.dcsr_cause_o), 32'd1);
    resume_now();

    // Single step.
    halt_now();
    dif.step_i = 1; dif.resumereq_i = 1; tick();
    chk("t23_rack", 32'(dif.resumeack_o), 32'd1);
    dif.resumereq_i = 0; tick();
    clr(); dif.pc_i = 32'h100; dif.instruction_retired_i = 1; tick();
    clr(); dif.pipe_idle_i = 1; tick();
    chk("t23_cause", 32'(dif.dcsr_cause_o), 32'd4);
    chk("t23_dpc", dif.dpc_o, 32'h100);
    resume_now();

    // Trigger exception request.
    clr(); dif.trigger_exception_req_i = 1; dif.pc_i = 32'h2000; tick();
    chk("t24_exc", 32'(dif.exc_req_o), 32'd1);
    chk("t24_tval", dif.exc_tval_o, 32'h2000);
    clr(); tick();
    chk("t24_exc_once", 32'(dif.exc_req_o), 32'd0);
    dif.trigger_exception_req_i = 1; dif.haltreq_i = 1; tick();
    chk("t24_exc_drop", 32'(dif.exc_req_o), 32'd0);
    clr(); dif.pipe_idle_i = 1; tick();
    resume_now();

    // Flush timeout, then reset mid-flush.
    clr(); dif.ebreak_i = 1; tick();
    clr();
    for (int i = 0; i < TO; i++) tick();
    chk("t25_not_yet", 32'(dif.halted_o), 32'd0);
    tick();
    chk("t25_timeout", 32'(dif.halted_o), 32'd1);
    resume_now();
    clr(); dif.ebreak_i = 1; tick();
    clr(); tick(); tick();
    async_reset();
    chk("t25_rst_flush", 32'(dif.flush_req_o), 32'd0);

    // Resume request masked by haltreq, then haltreq persisting past resume.
    halt_now();
    dif.resumereq_i = 1; dif.haltreq_i = 1; tick();
    chk("t26_stay", 32'(dif.halted_o), 32'd1);
    chk("t26_no_rack", 32'(dif.resumeack_o), 32'd0);
    dif.resumereq_i = 0; dif.dret_i = 1; tick();
    dif.dret_i = 0; tick();
    tick();
    chk("t15_reflush", 32'(dif.flush_req_o), 32'd1);
    clr(); dif.pipe_idle_i = 1; tick();
    chk("t15_cause", 32'(dif.dcsr_cause_o), 32'd3);
    resume_now();

    // Randomized traffic.
    clr();
    for (int n = 0; n < 4000; n++) begin
      dif.trigger_fire_i          = ($urandom_range(0, 23) == 0);
      dif.ebreak_i                = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 19) == 0) dif.haltreq_i = ~dif.haltreq_i;
      dif.trigger_exception_req_i = ($urandom_range(0, 5) == 0);
      dif.resumereq_i             = ($urandom_range(0, 2) == 0);
      dif.dret_i                  = ($urandom_range(0, 15) == 0);
      dif.step_i                  = ($urandom_range(0, 1) == 0);
      dif.instruction_retired_i   = ($urandom_range(0, 1) == 0);
      dif.pipe_idle_i             = ($urandom_range(0, 7) == 0);
      dif.pc_i                    = $urandom;
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_entry_ctrl.md
DEBUG_ENTRY_CTRL -- requirements
Module: debug_entry_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 255, max cycles waited for pipe_idle_i before forced entry.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  core clock
- reset_n  in  1  reset; asynchronous, active-low
- trigger_fire_i  in  1  registered trigger action=debug request
- trigger_exception_req_i  in  1  registered trigger action=exception request
- ebreak_i  in  1  retiring ebreak with dcsr.ebreakm=1
- haltreq_i  in  1  DM halt request, level
- resumereq_i  in  1  DM resume request, level
- dret_i  in  1  dret executed from program buffer
- step_i  in  1  dcsr.step
- instruction_retired_i  in  1  one instruction retired this cycle
- pc_i  in  32  PC of the oldest unretired instruction
- pipe_idle_i  in  1  pipeline drained after flush
- flush_req_o  out  1  flush/stall pipeline
- debug_mode_o  out  1  hart in Debug Mode
- halted_o  out  1  status to DM
- resumeack_o  out  1  one-cycle resume acknowledge
- dpc_we_o  out  1  dpc write strobe
- dpc_o  out  32  dpc write data
- dcsr_cause_we_o  out  1  dcsr.cause write strobe
- dcsr_cause_o  out  3  dcsr.cause write data
- exc_req_o  out  1  one-cycle breakpoint exception request
- exc_cause_o  out  4  fixed 4'd3 (breakpoint)
- exc_tval_o  out  32  faulting PC

Function
REQ-003 SHALL implement FSM states RUN, FLUSH, HALTED, RESUME.
REQ-004 SHALL treat RUN halt event = trigger_fire_i | ebreak_i | haltreq_i | step_done.
REQ-005 SHALL resolve cause by priority: trigger(2) > ebreak(1) > haltreq(3) > step(4).
REQ-006 SHALL, on event in RUN at cycle N, latch cause and pc_i, and enter FLUSH with flush_req_o=1 from N+1.
REQ-007 SHALL in FLUSH hold flush_req_o=1, ignore new events, count cycles with an 8-bit-or-wider counter.
REQ-008 SHALL leave FLUSH on pipe_idle_i=1 or count==FLUSH_TIMEOUT; the next cycle: HALTED, debug_mode_o=1, halted_o=1, one-cycle dpc_we_o and dcsr_cause_we_o carrying latched values.
REQ-009 SHALL keep flush_req_o=1 in HALTED.
REQ-010 SHALL in HALTED go to RESUME on dret_i, or on resumereq_i while haltreq_i=0; resumereq_i while haltreq_i=1 ignored.
REQ-011 SHALL in RESUME (one cycle) pulse resumeack_o, drop flush_req_o, debug_mode_o, halted_o, arm step_pending=step_i, return to RUN.
REQ-012 SHALL set step_done on the first instruction_retired_i in RUN with step_pending=1 and clear step_pending then; an asynchronous event in the same cycle wins by priority.
REQ-013 SHALL, in RUN with no halt event, pulse exc_req_o one cycle after trigger_exception_req_i with exc_tval_o=pc_i sampled at the request cycle.
REQ-014 SHALL drop trigger_exception_req_i coinciding with any halt event, or while not in RUN.
REQ-015 SHALL ignore haltreq_i in HALTED/RESUME; a haltreq_i still high in RUN after RESUME re-enters FLUSH with cause 3.
REQ-016 SHALL keep exc_cause_o constant 4'd3.

Reset
REQ-017 SHALL on reset_n low go to RUN asynchronously, including mid-FLUSH/HALTED.
REQ-018 SHALL reset all outputs to 0 except exc_cause_o; clear step_pending, counter, latched cause/pc.

Structure
REQ-019 SHALL take state enum and DCSR_CAUSE_* constants (1..5) from shared package debug_pkg.
REQ-020 SHALL be a single module; no sub-module.

Verification
REQ-021 trigger_fire_i=1, pc_i=0x80000010, pipe_idle_i after 3 cycles -> flush_req_o next cycle, HALTED, dpc_o=0x80000010, dcsr_cause_o=2.
REQ-022 trigger_fire_i, ebreak_i, haltreq_i same cycle -> dcsr_cause_o=2; ebreak_i+haltreq_i only -> 1.
REQ-023 HALTED, step_i=1, resumereq_i -> resumeack_o pulse; one retire at pc 0x100 -> halt, cause 4, dpc_o=pc_i of the retire cycle.
REQ-024 trigger_exception_req_i alone, pc_i=0x2000 -> exc_req_o one cycle later, exc_tval_o=0x2000, exc_cause_o=3; same cycle with haltreq_i -> no exc_req_o.
REQ-025 pipe_idle_i never asserted -> HALTED after FLUSH_TIMEOUT+1 cycles; reset_n low in FLUSH -> all outputs 0, RUN.
REQ-026 HALTED, resumereq_i=1 with haltreq_i=1 -> stay HALTED, no resumeack_o.
